// File: rtl/byte_serializer_pkg.sv
// Shared types and constants for the byte serializer: FSM state encoding and default word width.
package byte_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

endpackage

// File: rtl/byte_serializer_if.sv
// Parallel-in / serial-out handshake bundle; master drives din/load, slave returns ready and the serial stream.
interface byte_serializer_if import byte_serializer_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic             done;

  modport master (
    output din, load,
    input  ready, sout, sout_valid, done
  );

  modport slave (
    input  din, load,
    output ready, sout, sout_valid, done
  );

endinterface

// File: rtl/byte_serializer_bit_counter.sv
// Frame bit counter: clear on load, increment while shifting, flag and hold at WIDTH-1.
// Registered count, terminal flag decoded combinationally from the register.
module bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CW'(WIDTH - 1));

  // Saturating at the terminal count keeps the counter from wrapping inside a frame.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial shifter: first bit one cycle after accept, WIDTH bits (+1 parity with BYTE_SERIALIZER_PARITY_EN).
// ready only in IDLE; loads while busy are dropped, not queued.
module byte_serializer import byte_serializer_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              reset,
  byte_serializer_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             accept;
  logic             cnt_inc;
  logic             cnt_tc;
  logic             shift_bit;

  assign accept    = (state_q == ST_IDLE) && bus.load;
  assign shift_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clr_i (accept),
    .inc_i (cnt_inc),
    .tc_o  (cnt_tc)
  );

`ifdef BYTE_SERIALIZER_PARITY_EN
  // Parity is captured with the word because the shift register is consumed while shifting.
  logic par_q, par_d;

  assign par_d = accept ? ^bus.din : par_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          state_d = ST_SHIFT;
          shreg_d = bus.din;
        end
      end
      ST_SHIFT: begin
        shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
        if (cnt_tc) begin
`ifdef BYTE_SERIALIZER_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_inc = 1'b1;
        end
      end
`ifdef BYTE_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  assign bus.ready = (state_q == ST_IDLE);

`ifdef BYTE_SERIALIZER_PARITY_EN
  assign bus.sout_valid = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
  assign bus.sout       = (state_q == ST_SHIFT)  ? shift_bit :
                          (state_q == ST_PARITY) ? par_q     : 1'b0;
  assign bus.done       = (state_q == ST_PARITY);
`else
  assign bus.sout_valid = (state_q == ST_SHIFT);
  assign bus.sout       = (state_q == ST_SHIFT) ? shift_bit : 1'b0;
  assign bus.done       = (state_q == ST_SHIFT) && cnt_tc;
`endif

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: MSB-first and LSB-first instances driven in lockstep, table vectors plus random frames.
module tb_byte_serializer;

  localparam int W = 8;
`ifdef BYTE_SERIALIZER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  typedef struct {
    logic [7:0] din;
    logic [7:0] msb_seq;   // bit 7 is the first serial bit
    logic [7:0] lsb_seq;   // bit 7 is the first serial bit
    logic       par;
  } rec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  byte_serializer_if #(.WIDTH(W)) if_m ();
  byte_serializer_if #(.WIDTH(W)) if_l ();

  byte_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .bus(if_m));
  byte_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .bus(if_l));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic l);
    if_m.din  = d;
    if_m.load = l;
    if_l.din  = d;
    if_l.load = l;
  endtask

  // Reference: the k-th frame bit (1-based) taken straight from the word.
  function automatic logic model_bit(input logic [7:0] w, input bit msb, input int k);
    if (k > W) return ^w;
    return msb ? w[W-k] : w[k-1];
  endfunction

  function automatic rec_t model_rec(input logic [7:0] w);
    rec_t r;
    r.din = w;
    for (int k = 1; k <= W; k++) begin
      r.msb_seq[W-k] = model_bit(w, 1'b1, k);
      r.lsb_seq[W-k] = model_bit(w, 1'b0, k);
    end
    r.par = model_bit(w, 1'b1, W + 1);
    return r;
  endfunction

  function automatic logic rec_bit(input rec_t r, input int k, input bit msb);
    if (k > W) return r.par;
    return msb ? r.msb_seq[W-k] : r.lsb_seq[W-k];
  endfunction

  task automatic chk_cycle(input string tag, input logic em, input logic el, input logic ev,
                           input logic ed, input logic er);
    chk({tag, " sout_m"},  if_m.sout,       em);
    chk({tag, " sout_l"},  if_l.sout,       el);
    chk({tag, " valid_m"}, if_m.sout_valid, ev);
    chk({tag, " valid_l"}, if_l.sout_valid, ev);
    chk({tag, " done_m"},  if_m.done,       ed);
    chk({tag, " done_l"},  if_l.done,       ed);
    chk({tag, " ready_m"}, if_m.ready,      er);
    chk({tag, " ready_l"}, if_l.ready,      er);
  endtask

  // Called at a negedge with both DUTs idle; returns at the negedge of the idle cycle after the frame.
  task automatic frame(input rec_t r, input int mid_k, input logic [7:0] mid_din);
    string tag;
    chk_cycle($sformatf("pre %02h", r.din), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(r.din, 1'b1);
    @(negedge clk);
    drive(8'($urandom), 1'b0);
    for (int k = 1; k <= FL; k++) begin
      tag = $sformatf("frm %02h c%0d", r.din, k);
      chk_cycle(tag, rec_bit(r, k, 1'b1), rec_bit(r, k, 1'b0), 1'b1, (k == FL), 1'b0);
      if (k == mid_k) drive(mid_din, 1'b1);
      @(negedge clk);
      drive(8'($urandom), 1'b0);
    end
    chk_cycle($sformatf("post %02h", r.din), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rec_t tbl[8];
    rec_t r10, r19, rc6;
    tbl[0] = '{din: 8'hA5, msb_seq: 8'b10100101, lsb_seq: 8'b10100101, par: 1'b0};
    tbl[1] = '{din: 8'h41, msb_seq: 8'b01000001, lsb_seq: 8'b10000010, par: 1'b0};
    tbl[2] = '{din: 8'hF1, msb_seq: 8'b11110001, lsb_seq: 8'b10001111, par: 1'b1};
    tbl[3] = '{din: 8'h20, msb_seq: 8'b00100000, lsb_seq: 8'b00000100, par: 1'b1};
    tbl[4] = '{din: 8'hC6, msb_seq: 8'b11000110, lsb_seq: 8'b01100011, par: 1'b0};
    tbl[5] = '{din: 8'h49, msb_seq: 8'b01001001, lsb_seq: 8'b10010010, par: 1'b1};
    tbl[6] = '{din: 8'h10, msb_seq: 8'b00010000, lsb_seq: 8'b00001000, par: 1'b1};
    tbl[7] = '{din: 8'h19, msb_seq: 8'b00011001, lsb_seq: 8'b10011000, par: 1'b1};
    rc6 = tbl[4];
    r10 = tbl[6];
    r19 = tbl[7];

    // Reset held two cycles with load asserted: reset must win.
    drive(8'hFF, 1'b1);
    reset = 1'b0;
    #1;
    chk_cycle("rst t0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_cycle($sformatf("rst c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    reset = 1'b1;
    drive(8'h00, 1'b0);
    #1;
    chk_cycle("rst release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Table vectors; the first one is accepted on the first edge after release.
    for (int i = 0; i < 8; i++) begin
      frame(tbl[i], 0, 8'h00);
    end

    // Load of F1 while busy is dropped; F1 is taken only when re-presented.
    frame(tbl[3], 4, 8'hF1);
    frame(tbl[2], 0, 8'h00);

    // Reset in cycle 5 of a C6 frame aborts it with no done and no resume.
    drive(rc6.din, 1'b1);
    @(negedge clk);
    drive(8'h00, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      chk_cycle($sformatf("abort c%0d", k), rec_bit(rc6, k, 1'b1), rec_bit(rc6, k, 1'b0),
                1'b1, 1'b0, 1'b0);
      if (k < 5) @(negedge clk);
    end
    reset = 1'b0;
    #1;
    chk_cycle("abort rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_cycle("abort hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_cycle($sformatf("abort idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    frame(tbl[5], 0, 8'h00);

    // load held high: 10 then 19, exactly one idle cycle between frames.
    drive(r10.din, 1'b1);
    @(negedge clk);
    drive(r19.din, 1'b1);
    for (int k = 1; k <= 2 * FL + 1; k++) begin
      if (k <= FL) begin
        chk_cycle($sformatf("b2b a c%0d", k), rec_bit(r10, k, 1'b1), rec_bit(r10, k, 1'b0),
                  1'b1, (k == FL), 1'b0);
      end else if (k == FL + 1) begin
        chk_cycle("b2b gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        chk_cycle($sformatf("b2b b c%0d", k - FL - 1), rec_bit(r19, k - FL - 1, 1'b1),
                  rec_bit(r19, k - FL - 1, 1'b0), 1'b1, (k == 2 * FL + 1), 1'b0);
      end
      @(negedge clk);
      if (k >= FL + 1) drive(8'h00, 1'b0);
    end
    chk_cycle("b2b end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random words, random idle gaps, random ignored mid-frame loads.
    for (int i = 0; i < 20; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk_cycle($sformatf("rnd gap%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      frame(model_rec(8'($urandom)), $urandom_range(0, FL), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
